// File: rtl/move_validator_pkg.sv
// move_validator_pkg: shared chess definitions for the move validator.
//   Piece codes (0 empty, 1-6 black P N B R Q K, 7-12 white P N B R Q K),
//   piece-kind decoding, colour helpers, home rows, the square address
//   packing {x, y}, the FSM state encodings and the unit-step adder helper.
package move_validator_pkg;

  localparam logic [3:0] EMPTY    = 4'd0;
  localparam logic [3:0] B_PAWN   = 4'd1;
  localparam logic [3:0] B_KNIGHT = 4'd2;
  localparam logic [3:0] B_BISHOP = 4'd3;
  localparam logic [3:0] B_ROOK   = 4'd4;
  localparam logic [3:0] B_QUEEN  = 4'd5;
  localparam logic [3:0] B_KING   = 4'd6;
  localparam logic [3:0] W_PAWN   = 4'd7;
  localparam logic [3:0] W_KNIGHT = 4'd8;
  localparam logic [3:0] W_BISHOP = 4'd9;
  localparam logic [3:0] W_ROOK   = 4'd10;
  localparam logic [3:0] W_QUEEN  = 4'd11;
  localparam logic [3:0] W_KING   = 4'd12;

  // Black pawns start on row 1 and advance +y; white on row 6 and advance -y.
  localparam logic [2:0] BLACK_HOME_ROW = 3'd1;
  localparam logic [2:0] WHITE_HOME_ROW = 3'd6;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_GEOM = 3'd1;
  localparam logic [2:0] ST_WALK = 3'd2;
  localparam logic [2:0] ST_DEST = 3'd3;
  localparam logic [2:0] ST_FIN  = 3'd4;

  // Kind values line up with the black piece codes so decoding is a subtract.
  typedef enum logic [2:0] {
    KIND_NONE   = 3'd0,
    KIND_PAWN   = 3'd1,
    KIND_KNIGHT = 3'd2,
    KIND_BISHOP = 3'd3,
    KIND_ROOK   = 3'd4,
    KIND_QUEEN  = 3'd5,
    KIND_KING   = 3'd6
  } piece_kind_e;

  function automatic logic is_black(input logic [3:0] p);
    return (p >= B_PAWN) && (p <= B_KING);
  endfunction

  function automatic logic is_white(input logic [3:0] p);
    return (p >= W_PAWN) && (p <= W_KING);
  endfunction

  function automatic logic opposite_colour(input logic [3:0] a, input logic [3:0] b);
    return (is_black(a) && is_white(b)) || (is_white(a) && is_black(b));
  endfunction

  function automatic piece_kind_e piece_kind(input logic [3:0] p);
    if (is_black(p)) return piece_kind_e'(p[2:0]);
    if (is_white(p)) return piece_kind_e'(3'(p - 4'd6));
    return KIND_NONE;
  endfunction

  function automatic logic [5:0] pack_square(input logic [2:0] x, input logic [2:0] y);
    return {x, y};
  endfunction

  // Sign-extend a unit step to 3 bits; adding it modulo 8 moves one square.
  function automatic logic [2:0] step3(input logic signed [1:0] s);
    return {s[1], s};
  endfunction

endpackage

// File: rtl/move_validator_piece_geometry.sv
// piece_geometry: purely combinational move classifier.
//   Inputs : piece (4-bit code), origin_x/origin_y, destination_x/destination_y.
//   Outputs: geom_ok (shape legal for this piece), sx/sy (unit step toward the
//            destination), n (intermediate squares to check), and the
//            destination constraints for pawns (dest_must_be_empty /
//            dest_must_be_enemy). Non-pawns leave both constraints low and use
//            the generic capture rule in the top level.
module piece_geometry
  import move_validator_pkg::*;
(
  input  logic              [3:0] piece,
  input  logic              [2:0] origin_x,
  input  logic              [2:0] origin_y,
  input  logic              [2:0] destination_x,
  input  logic              [2:0] destination_y,
  output logic                    geom_ok,
  output logic signed       [1:0] sx,
  output logic signed       [1:0] sy,
  output logic              [2:0] n,
  output logic                    dest_must_be_empty,
  output logic                    dest_must_be_enemy
);

  logic signed [3:0] dx, dy;
  logic        [2:0] adx, ady, amax;
  logic              straight, diagonal, black;
  logic signed [3:0] fwd, fwd2;
  logic        [2:0] home;
  piece_kind_e       kind;

  assign dx   = signed'({1'b0, destination_x}) - signed'({1'b0, origin_x});
  assign dy   = signed'({1'b0, destination_y}) - signed'({1'b0, origin_y});
  assign adx  = dx[3] ? 3'(-dx) : dx[2:0];
  assign ady  = dy[3] ? 3'(-dy) : dy[2:0];
  assign amax = (adx > ady) ? adx : ady;

  assign straight = (dx == 4'sd0) != (dy == 4'sd0);
  assign diagonal = (adx == ady) && (adx != 3'd0);

  assign kind  = piece_kind(piece);
  assign black = is_black(piece);
  assign fwd   = black ? 4'sd1 : -4'sd1;
  assign fwd2  = black ? 4'sd2 : -4'sd2;
  assign home  = black ? BLACK_HOME_ROW : WHITE_HOME_ROW;

  always_comb begin
    geom_ok            = 1'b0;
    n                  = 3'd0;
    dest_must_be_empty = 1'b0;
    dest_must_be_enemy = 1'b0;
    sx = (dx == 4'sd0) ? 2'sd0 : (dx[3] ? -2'sd1 : 2'sd1);
    sy = (dy == 4'sd0) ? 2'sd0 : (dy[3] ? -2'sd1 : 2'sd1);

    case (kind)
      KIND_KNIGHT: geom_ok = ((adx == 3'd1) && (ady == 3'd2)) || ((adx == 3'd2) && (ady == 3'd1));
      KIND_KING:   geom_ok = (amax == 3'd1);
      KIND_ROOK: begin
        geom_ok = straight;
        n       = amax - 3'd1;
      end
      KIND_BISHOP: begin
        geom_ok = diagonal;
        n       = amax - 3'd1;
      end
      KIND_QUEEN: begin
        geom_ok = straight || diagonal;
        n       = amax - 3'd1;
      end
      KIND_PAWN: begin
        if ((dx == 4'sd0) && (dy == fwd)) begin
          geom_ok            = 1'b1;
          dest_must_be_empty = 1'b1;
        end else if ((dx == 4'sd0) && (dy == fwd2) && (origin_y == home)) begin
          geom_ok            = 1'b1;
          n                  = 3'd1;
          dest_must_be_empty = 1'b1;
        end else if ((adx == 3'd1) && (dy == fwd)) begin
          geom_ok            = 1'b1;
          dest_must_be_enemy = 1'b1;
        end
      end
      default: geom_ok = 1'b0;
    endcase

    // A null move is never legal, whatever the piece.
    if ((dx == 4'sd0) && (dy == 4'sd0)) geom_ok = 1'b0;
  end

endmodule

// File: rtl/move_validator.sv
// move_validator: reads the board memory and decides whether a move is legal.
//   clk, reset (async, active-high)
//   start                 one-cycle request, sampled only when idle
//   origin_x/origin_y     source square; destination_x/destination_y target
//   piece_to_move         piece code at the origin
//   piece_read            board data for address_validator, READ_LATENCY later
//   address_validator     read address {x, y}
//   busy                  high from accepted start until the verdict cycle
//   done                  one-cycle verdict strobe
//   valid                 verdict, held until the next accepted start
// The walk visits every square strictly between origin and destination, then
// the destination itself, waiting READ_LATENCY clocks on each address.
module move_validator
  import move_validator_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] origin_x,
  input  logic [2:0] origin_y,
  input  logic [2:0] destination_x,
  input  logic [2:0] destination_y,
  input  logic [3:0] piece_to_move,
  input  logic [3:0] piece_read,
  output logic [5:0] address_validator,
  output logic       busy,
  output logic       done,
  output logic       valid
);

  localparam int LAT_W = $clog2(READ_LATENCY + 1) + 1;

  logic [2:0]       state;
  logic [LAT_W-1:0] lat;
  logic [2:0]       walk_k;

  // Request registers: data only, loaded on an accepted start.
  logic [3:0] piece_q;
  logic [2:0] ox_q, oy_q, tx_q, ty_q;

  logic              geom_ok, must_empty, must_enemy, verdict, accept, read_ready;
  logic signed [1:0] sx, sy;
  logic        [2:0] n;

  assign accept     = (state == ST_IDLE) && start;
  assign read_ready = (lat == LAT_W'(READ_LATENCY));

  piece_geometry u_geom (
    .piece              (piece_q),
    .origin_x           (ox_q),
    .origin_y           (oy_q),
    .destination_x      (tx_q),
    .destination_y      (ty_q),
    .geom_ok            (geom_ok),
    .sx                 (sx),
    .sy                 (sy),
    .n                  (n),
    .dest_must_be_empty (must_empty),
    .dest_must_be_enemy (must_enemy)
  );

  // Pawns carry explicit destination constraints; everything else may land on
  // an empty square or capture the opposite colour.
  always_comb begin
    verdict = 1'b0;
    if (must_empty)      verdict = (piece_read == EMPTY);
    else if (must_enemy) verdict = opposite_colour(piece_q, piece_read);
    else                 verdict = (piece_read == EMPTY) || opposite_colour(piece_q, piece_read);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      piece_q <= piece_to_move;
      ox_q    <= origin_x;
      oy_q    <= origin_y;
      tx_q    <= destination_x;
      ty_q    <= destination_y;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      address_validator <= 6'd0;
      valid             <= 1'b0;
      lat               <= '0;
      walk_k            <= 3'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            valid <= 1'b0;
            state <= ST_GEOM;
          end
        end
        ST_GEOM: begin
          lat <= '0;
          if (!geom_ok) begin
            state <= ST_FIN;
          end else if (n != 3'd0) begin
            address_validator <= pack_square(ox_q + step3(sx), oy_q + step3(sy));
            walk_k            <= 3'd1;
            state             <= ST_WALK;
          end else begin
            address_validator <= pack_square(tx_q, ty_q);
            state             <= ST_DEST;
          end
        end
        ST_WALK: begin
          if (!read_ready) begin
            lat <= lat + 1'b1;
          end else if (piece_read != EMPTY) begin
            state <= ST_FIN;
          end else if (walk_k == n) begin
            address_validator <= pack_square(tx_q, ty_q);
            lat               <= '0;
            state             <= ST_DEST;
          end else begin
            address_validator <= pack_square(address_validator[5:3] + step3(sx),
                                             address_validator[2:0] + step3(sy));
            walk_k            <= walk_k + 3'd1;
            lat               <= '0;
          end
        end
        ST_DEST: begin
          if (!read_ready) begin
            lat <= lat + 1'b1;
          end else begin
            valid <= verdict;
            state <= ST_FIN;
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign done = (state == ST_FIN);
  assign busy = (state == ST_GEOM) || (state == ST_WALK) || (state == ST_DEST);

endmodule

// File: tb/tb_move_validator.sv
// tb_move_validator: directed bench for move_validator with a registered
// (one-cycle) board memory model. Cycle numbers count rising edges from the
// edge that accepts start (cycle 1); done is observed just after edge N.
module tb_move_validator;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [2:0] ox, oy, tx, ty;
  logic [3:0] piece, piece_read;
  logic [5:0] address;
  logic       busy, done, valid;

  logic [3:0] board [64];
  logic [5:0] alog  [64];
  int errors = 0;
  int checks = 0;
  int ndone;

  always #5 clk = ~clk;

  always @(posedge clk) piece_read <= board[address];

  move_validator #(.READ_LATENCY(1)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .origin_x          (ox),
    .origin_y          (oy),
    .destination_x     (tx),
    .destination_y     (ty),
    .piece_to_move     (piece),
    .piece_read        (piece_read),
    .address_validator (address),
    .busy              (busy),
    .done              (done),
    .valid             (valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_board();
    for (int i = 0; i < 64; i++) board[i] = 4'd0;
  endtask

  task automatic put(input logic [2:0] x, input logic [2:0] y, input logic [3:0] p);
    board[{x, y}] = p;
  endtask

  task automatic count_dones(input int ncyc, output int cnt);
    cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) cnt++;
    end
  endtask

  task automatic run_move(input string tag, input logic [3:0] p,
                          input logic [2:0] a, input logic [2:0] b,
                          input logic [2:0] c, input logic [2:0] d,
                          input bit restart, input int exp_cycle, input logic exp_valid);
    int cyc;
    @(negedge clk);
    piece = p; ox = a; oy = b; tx = c; ty = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 1;
    check({tag, ".busy_after_start"}, 32'(busy), 32'd1);
    check({tag, ".valid_cleared"}, 32'(valid), 32'd0);
    while (done !== 1'b1 && cyc < 200) begin
      if (restart && cyc == 2) begin
        start = 1'b1;
        piece = 4'd0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc < 64) alog[cyc] = address;
    end
    start = 1'b0;
    check({tag, ".done_seen"}, 32'(done), 32'd1);
    check({tag, ".done_cycle"}, 32'(cyc), 32'(exp_cycle));
    check({tag, ".valid"}, 32'(valid), 32'(exp_valid));
    check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    check({tag, ".done_one_cycle"}, 32'(done), 32'd0);
    check({tag, ".valid_held"}, 32'(valid), 32'(exp_valid));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    piece = 4'd0; ox = 3'd0; oy = 3'd0; tx = 3'd0; ty = 3'd0;
    clear_board();
    repeat (2) @(posedge clk);
    #1;
    check("reset.address", 32'(address), 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.valid", 32'(valid), 32'd0);
    @(negedge clk); reset = 1'b0;

    // Reset in the middle of a walk: black rook 0,0 -> 0,7.
    @(negedge clk);
    piece = 4'd4; ox = 3'd0; oy = 3'd0; tx = 3'd0; ty = 3'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("rst_walk.address_before", 32'(address), 32'd2);
    check("rst_walk.busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_walk.address", 32'(address), 32'd0);
    check("rst_walk.busy", 32'(busy), 32'd0);
    check("rst_walk.done", 32'(done), 32'd0);
    @(negedge clk); reset = 1'b0;
    count_dones(24, ndone);
    check("rst_walk.no_done", 32'(ndone), 32'd0);
    check("rst_walk.busy_after", 32'(busy), 32'd0);

    // White rook down an empty file: six intermediates then the destination.
    clear_board();
    run_move("rook_w", 4'd10, 3'd0, 3'd7, 3'd0, 3'd0, 1'b0, 16, 1'b1);
    check("rook_w.addr_c2", 32'(alog[2]), 32'd6);
    check("rook_w.addr_c4", 32'(alog[4]), 32'd5);
    check("rook_w.addr_c12", 32'(alog[12]), 32'd1);
    check("rook_w.addr_c14", 32'(alog[14]), 32'd0);

    // Black bishop blocked on its first intermediate square.
    clear_board();
    put(3'd3, 3'd1, 4'd1);
    run_move("bishop_blk", 4'd3, 3'd2, 3'd0, 3'd5, 3'd3, 1'b0, 4, 1'b0);
    check("bishop_blk.addr", 32'(address), 32'({3'd3, 3'd1}));

    // White knight capturing black pawn, then landing on own pawn.
    clear_board();
    put(3'd5, 3'd5, 4'd1);
    run_move("knight_cap", 4'd8, 3'd6, 3'd7, 3'd5, 3'd5, 1'b0, 4, 1'b1);
    put(3'd5, 3'd5, 4'd7);
    run_move("knight_own", 4'd8, 3'd6, 3'd7, 3'd5, 3'd5, 1'b0, 4, 1'b0);

    // Pawns: double push from home, double push off home, captures.
    clear_board();
    run_move("bpawn_dbl", 4'd1, 3'd4, 3'd1, 3'd4, 3'd3, 1'b0, 6, 1'b1);
    run_move("bpawn_dbl_nohome", 4'd1, 3'd4, 3'd2, 3'd4, 3'd4, 1'b0, 2, 1'b0);
    run_move("wpawn_cap_empty", 4'd7, 3'd3, 3'd6, 3'd2, 3'd5, 1'b0, 4, 1'b0);
    put(3'd2, 3'd5, 4'd2);
    run_move("wpawn_cap", 4'd7, 3'd3, 3'd6, 3'd2, 3'd5, 1'b0, 4, 1'b1);
    run_move("wpawn_push_blocked", 4'd7, 3'd2, 3'd6, 3'd2, 3'd5, 1'b0, 4, 1'b0);

    // White queen on a clear diagonal onto its own pawn.
    clear_board();
    put(3'd6, 3'd6, 4'd7);
    run_move("queen_own", 4'd11, 3'd3, 3'd3, 3'd6, 3'd6, 1'b0, 8, 1'b0);

    // Degenerate requests.
    clear_board();
    run_move("empty_piece", 4'd0, 3'd0, 3'd0, 3'd1, 3'd1, 1'b0, 2, 1'b0);
    run_move("null_move", 4'd4, 3'd3, 3'd3, 3'd3, 3'd3, 1'b0, 2, 1'b0);
    run_move("bad_code", 4'd13, 3'd0, 3'd0, 3'd0, 3'd1, 1'b0, 2, 1'b0);

    // A second start during the walk must be ignored.
    clear_board();
    run_move("restart", 4'd10, 3'd0, 3'd7, 3'd0, 3'd0, 1'b1, 16, 1'b1);
    count_dones(20, ndone);
    check("restart.no_second_done", 32'(ndone), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
